// File: rtl/branch_predictor_pkg.sv
// Pipeline-wide constants shared by fetch, decode and the branch predictor.
// Word size, opcode/func encodings and the 2-bit counter reset/allocation values.
package branch_predictor_pkg;

   localparam int WORD_SIZE = 16;

   typedef logic [WORD_SIZE-1:0] word_t;

   localparam logic [3:0] OPCODE_BNE = 4'd0;
   localparam logic [3:0] OPCODE_BEQ = 4'd1;
   localparam logic [3:0] OPCODE_BGZ = 4'd2;
   localparam logic [3:0] OPCODE_BLZ = 4'd3;
   localparam logic [3:0] OPCODE_JMP = 4'd9;
   localparam logic [3:0] OPCODE_JAL = 4'd10;
   localparam logic [3:0] OPCODE_RTYPE = 4'd15;

   localparam logic [5:0] FUNC_JPR = 6'd25;
   localparam logic [5:0] FUNC_JRL = 6'd26;

   // Weakly not-taken after reset, weakly taken on allocation by a taken branch.
   localparam logic [1:0] CNT_RESET = 2'd1;
   localparam logic [1:0] CNT_ALLOC = 2'd2;

   function automatic logic cnt_predicts_taken(input logic [1:0] cnt);
      return cnt[1];
   endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter with synchronous load; load beats inc/dec.
// One cycle from inc/dec/load to cnt_o; synchronous reset to the weakly not-taken value.
module sat_counter2
   import branch_predictor_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load_i,
   input  logic [1:0] load_val_i,
   input  logic       inc_i,
   input  logic       dec_i,
   output logic [1:0] cnt_o
);

   logic [1:0] cnt_q;
   logic [1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (inc_i && (cnt_q != 2'd3)) begin
         cnt_d = cnt_q + 2'd1;
      end else if (dec_i && (cnt_q != 2'd0)) begin
         cnt_d = cnt_q - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= CNT_RESET;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit counters; lookup and miss outputs are combinational.
// Table updates land on the clock edge and are visible to lookups from the following cycle.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int PREDICTION     = 1,
   parameter int BTB_INDEX_BITS = 4
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WORD_SIZE-1:0] pc_if,
   output logic [WORD_SIZE-1:0] predicted_pc,
   input  logic                 jmp_valid,
   input  logic [WORD_SIZE-1:0] jmp_pc,
   input  logic [WORD_SIZE-1:0] jmp_target,
   input  logic [WORD_SIZE-1:0] jmp_pred_next,
   input  logic                 id_stall,
   input  logic                 br_valid,
   input  logic [WORD_SIZE-1:0] br_pc,
   input  logic                 br_taken,
   input  logic [WORD_SIZE-1:0] br_target,
   input  logic [WORD_SIZE-1:0] br_pred_next,
   output logic                 jump_miss,
   output logic                 branch_miss,
   output logic [WORD_SIZE-1:0] correct_pc
);

   localparam int N       = 1 << BTB_INDEX_BITS;
   localparam int TAG_W   = WORD_SIZE - BTB_INDEX_BITS;
   localparam bit PRED_ON = (PREDICTION != 0);

   typedef logic [BTB_INDEX_BITS-1:0] idx_t;
   typedef logic [TAG_W-1:0]          tag_t;

   logic [N-1:0] valid_q, valid_d;
   logic [N-1:0] is_jump_q, is_jump_d;
   tag_t         tag_q    [N];
   tag_t         tag_d    [N];
   word_t        target_q [N];
   word_t        target_d [N];
   logic [1:0]   cnt      [N];

   idx_t  if_idx, br_idx, jmp_idx;
   tag_t  if_tag, br_tag, jmp_tag;
   logic  if_hit, if_taken, br_hit;
   logic  br_upd, br_alloc, jmp_wr;
   word_t br_actual;

   assign if_idx  = pc_if[BTB_INDEX_BITS-1:0];
   assign if_tag  = pc_if[WORD_SIZE-1:BTB_INDEX_BITS];
   assign br_idx  = br_pc[BTB_INDEX_BITS-1:0];
   assign br_tag  = br_pc[WORD_SIZE-1:BTB_INDEX_BITS];
   assign jmp_idx = jmp_pc[BTB_INDEX_BITS-1:0];
   assign jmp_tag = jmp_pc[WORD_SIZE-1:BTB_INDEX_BITS];

   assign if_hit   = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign if_taken = if_hit && (is_jump_q[if_idx] || cnt_predicts_taken(cnt[if_idx]));
   assign predicted_pc = (PRED_ON && if_taken) ? target_q[if_idx] : pc_if + word_t'(1);

   assign br_actual   = br_taken ? br_target : br_pc + word_t'(1);
   assign branch_miss = br_valid && (!PRED_ON || (br_pred_next != br_actual));
   // A mispredicted branch in EX flushes ID, so the jump there is squashed.
   assign jump_miss   = jmp_valid && !id_stall && !branch_miss &&
                        (!PRED_ON || (jmp_pred_next != jmp_target));
   assign correct_pc  = branch_miss ? br_actual :
                        jump_miss   ? jmp_target : word_t'(0);

   assign br_hit   = valid_q[br_idx] && (tag_q[br_idx] == br_tag);
   assign br_upd   = PRED_ON && br_valid && br_hit;
   assign br_alloc = PRED_ON && br_valid && br_taken && !br_hit;
   assign jmp_wr   = PRED_ON && jmp_valid && !id_stall && !branch_miss;

   // Jump write comes last so its fields win on an index collision.
   always_comb begin
      valid_d   = valid_q;
      is_jump_d = is_jump_q;
      tag_d     = tag_q;
      target_d  = target_q;
      if (br_alloc) begin
         valid_d[br_idx]   = 1'b1;
         is_jump_d[br_idx] = 1'b0;
         tag_d[br_idx]     = br_tag;
         target_d[br_idx]  = br_target;
      end
      if (jmp_wr) begin
         valid_d[jmp_idx]   = 1'b1;
         is_jump_d[jmp_idx] = 1'b1;
         tag_d[jmp_idx]     = jmp_tag;
         target_d[jmp_idx]  = jmp_target;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
      end else begin
         valid_q   <= valid_d;
         is_jump_q <= is_jump_d;
         for (int i = 0; i < N; i++) begin
            tag_q[i]    <= tag_d[i];
            target_q[i] <= target_d[i];
         end
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_cnt
      logic sel_br;
      assign sel_br = (br_idx == idx_t'(i));
      sat_counter2 u_cnt (
         .clk        (clk),
         .reset      (reset),
         .load_i     (br_alloc && sel_br),
         .load_val_i (CNT_ALLOC),
         .inc_i      (br_upd && sel_br && br_taken),
         .dec_i      (br_upd && sel_br && !br_taken),
         .cnt_o      (cnt[i])
      );
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus random traffic on a predicting and a
// non-predicting instance, both checked against a table model kept as plain arrays.
module tb_branch_predictor;

   logic        clk;
   logic        reset;
   logic [15:0] pc_if;
   logic        jmp_valid;
   logic [15:0] jmp_pc, jmp_target, jmp_pred_next;
   logic        id_stall;
   logic        br_valid;
   logic [15:0] br_pc;
   logic        br_taken;
   logic [15:0] br_target, br_pred_next;

   logic [15:0] p1_predicted_pc, p1_correct_pc;
   logic        p1_jump_miss, p1_branch_miss;
   logic [15:0] p0_predicted_pc, p0_correct_pc;
   logic        p0_jump_miss, p0_branch_miss;

   int n_vec = 0;
   int n_err = 0;

   // Reference table: 16 entries, index = pc mod 16, tag = pc div 16.
   bit m_valid  [16];
   int m_tag    [16];
   int m_target [16];
   bit m_isj    [16];
   int m_cnt    [16];

   branch_predictor #(.PREDICTION(1), .BTB_INDEX_BITS(4)) dut1 (
      .clk(clk), .reset(reset), .pc_if(pc_if), .predicted_pc(p1_predicted_pc),
      .jmp_valid(jmp_valid), .jmp_pc(jmp_pc), .jmp_target(jmp_target),
      .jmp_pred_next(jmp_pred_next), .id_stall(id_stall),
      .br_valid(br_valid), .br_pc(br_pc), .br_taken(br_taken), .br_target(br_target),
      .br_pred_next(br_pred_next), .jump_miss(p1_jump_miss), .branch_miss(p1_branch_miss),
      .correct_pc(p1_correct_pc)
   );

   branch_predictor #(.PREDICTION(0), .BTB_INDEX_BITS(4)) dut0 (
      .clk(clk), .reset(reset), .pc_if(pc_if), .predicted_pc(p0_predicted_pc),
      .jmp_valid(jmp_valid), .jmp_pc(jmp_pc), .jmp_target(jmp_target),
      .jmp_pred_next(jmp_pred_next), .id_stall(id_stall),
      .br_valid(br_valid), .br_pc(br_pc), .br_taken(br_taken), .br_target(br_target),
      .br_pred_next(br_pred_next), .jump_miss(p0_jump_miss), .branch_miss(p0_branch_miss),
      .correct_pc(p0_correct_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int model_pred(input int pc);
      int idx = pc % 16;
      int tag = pc / 16;
      if (m_valid[idx] && m_tag[idx] == tag && (m_isj[idx] || m_cnt[idx] >= 2))
         return m_target[idx];
      return (pc + 1) % 65536;
   endfunction

   function automatic int actual_next();
      return br_taken ? int'(br_target) : (int'(br_pc) + 1) % 65536;
   endfunction

   function automatic bit model_bmiss(input bit pred);
      return br_valid && (!pred || int'(br_pred_next) != actual_next());
   endfunction

   function automatic bit model_jmiss(input bit pred);
      return jmp_valid && !id_stall && !model_bmiss(pred) &&
             (!pred || jmp_pred_next != jmp_target);
   endfunction

   function automatic int model_cpc(input bit pred);
      if (model_bmiss(pred)) return actual_next();
      if (model_jmiss(pred)) return int'(jmp_target);
      return 0;
   endfunction

   task automatic model_update();
      int bi, bt, ji, jt;
      if (reset) begin
         for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 1;
         end
         return;
      end
      bi = int'(br_pc) % 16;
      bt = int'(br_pc) / 16;
      if (br_valid) begin
         if (m_valid[bi] && m_tag[bi] == bt) begin
            if (br_taken && m_cnt[bi] < 3) m_cnt[bi]++;
            if (!br_taken && m_cnt[bi] > 0) m_cnt[bi]--;
         end else if (br_taken) begin
            m_valid[bi] = 1'b1; m_tag[bi] = bt; m_target[bi] = br_target;
            m_isj[bi] = 1'b0; m_cnt[bi] = 2;
         end
      end
      if (jmp_valid && !id_stall && !model_bmiss(1'b1)) begin
         ji = int'(jmp_pc) % 16;
         jt = int'(jmp_pc) / 16;
         m_valid[ji] = 1'b1; m_tag[ji] = jt; m_target[ji] = jmp_target; m_isj[ji] = 1'b1;
      end
   endtask

   task automatic sample();
      @(negedge clk);
      check_eq("p1_predicted_pc", p1_predicted_pc, model_pred(pc_if));
      check_eq("p1_branch_miss", p1_branch_miss, model_bmiss(1'b1));
      check_eq("p1_jump_miss", p1_jump_miss, model_jmiss(1'b1));
      check_eq("p1_correct_pc", p1_correct_pc, model_cpc(1'b1));
      check_eq("p0_predicted_pc", p0_predicted_pc, (int'(pc_if) + 1) % 65536);
      check_eq("p0_branch_miss", p0_branch_miss, model_bmiss(1'b0));
      check_eq("p0_jump_miss", p0_jump_miss, model_jmiss(1'b0));
      check_eq("p0_correct_pc", p0_correct_pc, model_cpc(1'b0));
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_idle();
      reset = 1'b0; jmp_valid = 1'b0; jmp_pc = '0; jmp_target = '0; jmp_pred_next = '0;
      id_stall = 1'b0; br_valid = 1'b0; br_pc = '0; br_taken = 1'b0;
      br_target = '0; br_pred_next = '0;
   endtask

   task automatic do_branch(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                            input logic [15:0] pn);
      set_idle();
      br_valid = 1'b1; br_pc = pc; br_taken = tk; br_target = tgt; br_pred_next = pn;
   endtask

   function automatic logic [15:0] rand_pc();
      case ($urandom_range(0, 7))
         0: return 16'h0003;
         1: return 16'h0013;
         2: return 16'h0103;
         3: return 16'h0007;
         4: return 16'h0017;
         5: return 16'hFFFF;
         6: return 16'h000F;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      set_idle();
      pc_if = 16'h0010;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // Reset state: no prediction
      sample();
      check_eq("reset_pred", p1_predicted_pc, 16'h0011);
      tick();

      // Cold jump
      jmp_valid = 1'b1; jmp_pc = 16'h0010; jmp_target = 16'h0040; jmp_pred_next = 16'h0011;
      sample();
      check_eq("cold_jmp_miss", p1_jump_miss, 1);
      check_eq("cold_jmp_cpc", p1_correct_pc, 16'h0040);
      tick();
      set_idle(); pc_if = 16'h0010;
      sample();
      check_eq("cold_jmp_learned", p1_predicted_pc, 16'h0040);
      tick();

      // Counter training at 0x0020
      pc_if = 16'h0020;
      do_branch(16'h0020, 1'b1, 16'h0030, 16'h0021);
      sample(); tick();
      do_branch(16'h0020, 1'b1, 16'h0030, 16'h0030);
      sample();
      check_eq("train_cnt2", p1_predicted_pc, 16'h0030);
      check_eq("train_hit_nomiss", p1_branch_miss, 0);
      tick();
      do_branch(16'h0020, 1'b0, 16'h0030, 16'h0030);
      sample();
      check_eq("train_cnt3", p1_predicted_pc, 16'h0030);
      check_eq("train_nt_cpc", p1_correct_pc, 16'h0021);
      tick();
      set_idle();
      sample();
      check_eq("train_back2", p1_predicted_pc, 16'h0030);
      tick();

      // Reset mid-training, with a branch on the port that must be ignored
      do_branch(16'h0020, 1'b1, 16'h0030, 16'h0021);
      reset = 1'b1;
      tick();
      set_idle();
      sample();
      check_eq("reset_mid_0020", p1_predicted_pc, 16'h0021);
      tick();
      pc_if = 16'h0010;
      sample();
      check_eq("reset_mid_0010", p1_predicted_pc, 16'h0011);
      tick();

      // Retrain: alloc at 2, one not-taken drops below threshold, one taken restores it
      pc_if = 16'h0020;
      do_branch(16'h0020, 1'b1, 16'h0030, 16'h0021);
      sample(); tick();
      do_branch(16'h0020, 1'b0, 16'h0030, 16'h0030);
      sample(); tick();
      set_idle();
      sample();
      check_eq("cnt1_not_taken", p1_predicted_pc, 16'h0021);
      tick();
      do_branch(16'h0020, 1'b1, 16'h0030, 16'h0021);
      sample(); tick();
      set_idle();
      sample();
      check_eq("cnt2_taken_again", p1_predicted_pc, 16'h0030);
      tick();

      // Branch miss squashes the jump in ID
      do_branch(16'h0050, 1'b0, 16'h0055, 16'h0055);
      jmp_valid = 1'b1; jmp_pc = 16'h0060; jmp_target = 16'h0070; jmp_pred_next = 16'h0061;
      pc_if = 16'h0060;
      sample();
      check_eq("simul_bmiss", p1_branch_miss, 1);
      check_eq("simul_jmiss", p1_jump_miss, 0);
      check_eq("simul_cpc", p1_correct_pc, 16'h0051);
      tick();

      // Stalled jump, then the same jump released
      set_idle();
      jmp_valid = 1'b1; jmp_pc = 16'h0060; jmp_target = 16'h0070; jmp_pred_next = 16'h0061;
      id_stall = 1'b1;
      sample();
      check_eq("no_write_after_squash", p1_predicted_pc, 16'h0061);
      check_eq("stall_jmiss", p1_jump_miss, 0);
      tick();
      id_stall = 1'b0;
      sample();
      check_eq("stall_no_write", p1_predicted_pc, 16'h0061);
      check_eq("unstall_jmiss", p1_jump_miss, 1);
      check_eq("unstall_cpc", p1_correct_pc, 16'h0070);
      tick();
      set_idle();
      sample();
      check_eq("unstall_learned", p1_predicted_pc, 16'h0070);
      tick();

      // Branch allocation and jump write on the same index: jump wins
      do_branch(16'h0035, 1'b1, 16'h0090, 16'h0090);
      jmp_valid = 1'b1; jmp_pc = 16'h0045; jmp_target = 16'h0080; jmp_pred_next = 16'h0046;
      sample();
      check_eq("collide_jmiss", p1_jump_miss, 1);
      tick();
      set_idle(); pc_if = 16'h0045;
      sample();
      check_eq("collide_jump_wins", p1_predicted_pc, 16'h0080);
      tick();
      pc_if = 16'h0035;
      sample();
      check_eq("collide_branch_gone", p1_predicted_pc, 16'h0036);
      tick();

      // PC wrap
      pc_if = 16'hFFFF;
      sample();
      check_eq("wrap_p1", p1_predicted_pc, 16'h0000);
      check_eq("wrap_p0", p0_predicted_pc, 16'h0000);
      tick();

      // Random traffic
      for (int k = 0; k < 3000; k++) begin
         set_idle();
         reset    = ($urandom_range(0, 59) == 0);
         pc_if    = rand_pc();
         br_valid = $urandom_range(0, 1);
         br_pc    = rand_pc();
         br_taken = $urandom_range(0, 1);
         br_target = ($urandom_range(0, 1) != 0) ? 16'h0200 : 16'($urandom);
         case ($urandom_range(0, 2))
            0: br_pred_next = 16'(actual_next());
            1: br_pred_next = 16'(model_pred(br_pc));
            default: br_pred_next = 16'($urandom);
         endcase
         jmp_valid = $urandom_range(0, 1);
         id_stall  = ($urandom_range(0, 3) == 0);
         jmp_pc    = rand_pc();
         jmp_target = ($urandom_range(0, 1) != 0) ? 16'h0300 : 16'($urandom);
         case ($urandom_range(0, 2))
            0: jmp_pred_next = jmp_target;
            1: jmp_pred_next = 16'(model_pred(jmp_pc));
            default: jmp_pred_next = 16'($urandom);
         endcase
         sample();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
